// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one datapath access at a time, stalls the pipe
// for LATENCY cycles, then performs the RAM read/write in a single DONE cycle.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  wr_q;
  logic                  bad_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [31:0]           data_q;
  logic [31:0]           ram [DEPTH];

  logic                  req;
  logic                  bad_req;

  assign req = mem_ren | mem_wen;

  // Misaligned, beyond the RAM, or both strobes at once.
  assign bad_req = (mem_addr[1:0] != 2'b00) ||
                   ((mem_addr >> (ADDR_WIDTH + 2)) != '0) ||
                   (mem_ren && mem_wen);

  assign mem_stall = ((state == IDLE) && req && !rst) || (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_din <= '0;
      mem_err <= 1'b0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      word_q  <= '0;
      data_q  <= '0;
    end else begin
      mem_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            wr_q   <= mem_wen;
            bad_q  <= bad_req;
            word_q <= mem_addr[ADDR_WIDTH+1:2];
            data_q <= mem_dout;
            cnt    <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              state   <= DONE;
              mem_err <= bad_req;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          // mem_err is registered, so it is raised on the edge that enters DONE.
          if (cnt <= 4'd1) begin
            state   <= DONE;
            mem_err <= bad_q;
          end
        end
        DONE: begin
          state <= IDLE;
          if (bad_q)
            mem_din <= '0;
          else if (!wr_q)
            mem_din <= ram[word_q];
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never reset; a reset landing on DONE suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && (state == DONE) && wr_q && !bad_q)
      ram[word_q] <= data_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY=2 and LATENCY=1) driven by
// directed and random accesses, checked against an array-based memory model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, ren1, wen1, stall1, err1;
  logic [31:0] addr1, dout1, din1;
  logic        rst2, ren2, wen2, stall2, err2;
  logic [31:0] addr2, dout2, din2;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .mem_ren(ren1), .mem_wen(wen1), .mem_addr(addr1),
    .mem_dout(dout1), .mem_din(din1), .mem_stall(stall1), .mem_err(err1)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst2), .mem_ren(ren2), .mem_wen(wen2), .mem_addr(addr2),
    .mem_dout(dout2), .mem_din(din2), .mem_stall(stall2), .mem_err(err2)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m   [1:2][1024];
  bit          known_m [1:2][1024];
  logic [31:0] din_m   [1:2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 1) begin
      ren1 = r; wen1 = w; addr1 = a; dout1 = d;
    end else begin
      ren2 = r; wen2 = w; addr2 = a; dout2 = d;
    end
  endtask

  function automatic logic get_stall(input int sel);
    return (sel == 1) ? stall1 : stall2;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 1) ? err1 : err2;
  endfunction

  function automatic logic [31:0] get_din(input int sel);
    return (sel == 1) ? din1 : din2;
  endfunction

  function automatic int lat(input int sel);
    return (sel == 1) ? 1 : 2;
  endfunction

  // Caller is positioned just after a negedge in an IDLE cycle; returns in the
  // IDLE cycle right after DONE, so calls can be chained back-to-back.
  task automatic access(input int sel, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic exp_err;
    int   word;
    int   sc;
    exp_err = (a[1:0] != 2'b00) || ((a >> 12) != 0) || (r && w);
    word    = int'(a[11:2]);
    drive(sel, r, w, a, d);
    #1;
    sc = 0;
    for (int i = 0; i < 40 && get_stall(sel); i++) begin
      sc++;
      chk({tag, "_err_busy"}, 32'(get_err(sel)), 32'd0);
      chk({tag, "_din_hold"}, get_din(sel), din_m[sel]);
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, $urandom, $urandom);
      #1;
    end
    chk({tag, "_stall_len"}, 32'(sc), 32'(lat(sel)));
    chk({tag, "_err_done"}, 32'(get_err(sel)), 32'(exp_err));
    chk({tag, "_stall_done"}, 32'(get_stall(sel)), 32'd0);
    if (exp_err) begin
      din_m[sel] = '0;
    end else if (w) begin
      mem_m[sel][word]   = d;
      known_m[sel][word] = 1'b1;
    end else begin
      din_m[sel] = mem_m[sel][word];
    end
    @(negedge clk);
    #1;
    chk({tag, "_din"}, get_din(sel), din_m[sel]);
    chk({tag, "_err_after"}, 32'(get_err(sel)), 32'd0);
    chk({tag, "_stall_after"}, 32'(get_stall(sel)), 32'd0);
  endtask

  task automatic random_run(input int sel, input int n);
    int          k;
    int          wd;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      k  = $urandom_range(0, 9);
      wd = $urandom_range(0, 15);
      a  = 32'(wd) << 2;
      case (k)
        0: access(sel, 1'b1, 1'b0, a | 32'($urandom_range(1, 3)), 32'd0, "rnd_misal");
        1: access(sel, 1'b0, 1'b1, a | (32'($urandom_range(1, 255)) << 12), $urandom, "rnd_oor");
        2: access(sel, 1'b1, 1'b1, a, $urandom, "rnd_rw");
        default: begin
          if (k >= 6 && known_m[sel][wd])
            access(sel, 1'b1, 1'b0, a, 32'd0, "rnd_rd");
          else
            access(sel, 1'b0, 1'b1, a, $urandom, "rnd_wr");
        end
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst1 = 1'b1; ren1 = 1'b0; wen1 = 1'b0; addr1 = '0; dout1 = '0;
    rst2 = 1'b1; ren2 = 1'b1; wen2 = 1'b0; addr2 = 32'h10; dout2 = '0;
    din_m[1] = '0;
    din_m[2] = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall2", 32'(stall2), 32'd0);
    chk("rst_din2", din2, 32'd0);
    chk("rst_err2", 32'(err2), 32'd0);
    chk("rst_stall1", 32'(stall1), 32'd0);
    chk("rst_din1", din1, 32'd0);
    ren2 = 1'b0;
    @(negedge clk);
    rst1 = 1'b0;
    rst2 = 1'b0;
    #1;

    access(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
    access(2, 1'b1, 1'b0, 32'h10, 32'h0, "rd10");

    access(2, 1'b0, 1'b1, 32'h10, 32'h12345678, "wr10b");
    access(2, 1'b1, 1'b0, 32'h13, 32'h0, "rd13_misal");
    access(2, 1'b1, 1'b0, 32'h10, 32'h0, "rd10b");

    access(2, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, "wr0");
    access(2, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, "wr1000_oor");
    access(2, 1'b1, 1'b0, 32'h0, 32'h0, "rd0");

    access(2, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, "wr20");
    access(2, 1'b1, 1'b1, 32'h20, 32'h11111111, "rw20");
    access(2, 1'b1, 1'b0, 32'h20, 32'h0, "rd20");

    // Reset during the last BUSY cycle aborts the write to 0x40.
    access(2, 1'b0, 1'b1, 32'h40, 32'h600DF00D, "wr40");
    access(2, 1'b1, 1'b0, 32'h40, 32'h0, "rd40");
    drive(2, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5);
    #1;
    chk("rstmid_stall_req", 32'(stall2), 32'd1);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    din_m[2] = '0;
    chk("rstmid_stall", 32'(stall2), 32'd0);
    chk("rstmid_din", din2, 32'd0);
    chk("rstmid_err", 32'(err2), 32'd0);
    @(negedge clk);
    #1;
    chk("rstmid_no_done_err", 32'(err2), 32'd0);
    chk("rstmid_idle_stall", 32'(stall2), 32'd0);
    access(2, 1'b1, 1'b0, 32'h40, 32'h0, "rd40_after_rst");

    // Reset landing on the DONE cycle must suppress the write to 0x44.
    access(2, 1'b0, 1'b1, 32'h44, 32'h01234567, "wr44");
    drive(2, 1'b0, 1'b1, 32'h44, 32'h5A5A5A5A);
    #1;
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    chk("rstdone_stall", 32'(stall2), 32'd0);
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    din_m[2] = '0;
    chk("rstdone_din", din2, 32'd0);
    access(2, 1'b1, 1'b0, 32'h44, 32'h0, "rd44_after_rst");

    random_run(2, 30);

    access(1, 1'b0, 1'b1, 32'h0, 32'h13579BDF, "l1_wr0");
    access(1, 1'b0, 1'b1, 32'h4, 32'h2468ACE0, "l1_wr4");
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, "l1_rd0");
    access(1, 1'b1, 1'b0, 32'h4, 32'h0, "l1_rd4");
    access(1, 1'b1, 1'b0, 32'h6, 32'h0, "l1_rd6_misal");

    random_run(1, 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
